// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with standard/FWFT read, thresholds and sticky errors
// Pointers carry one extra wrap bit so all DEPTH entries are usable.
module sync_fifo_prog #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   parameter int FWFT  = 0,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW:0]      i_almost_full_lim,
   input  logic [AW:0]      i_almost_empty_lim,
   input  logic             i_clr_err,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_almost_full,
   output logic             o_almost_empty,
   output logic [AW:0]      o_count,
   output logic             o_overflow,
   output logic             o_underflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [AW:0]      count;
   logic             full, empty, wa, ra;

   // Status is a pure decode of the registered pointers.
   always_comb begin
      count = wr_ptr_q - rd_ptr_q;
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty = (wr_ptr_q == rd_ptr_q);
      wa    = i_wr_en & ~full;
      ra    = i_rd_en & ~empty;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wa) wr_ptr_d = wr_ptr_q + 1'b1;
      if (ra) rd_ptr_d = rd_ptr_q + 1'b1;
      ovf_d = (ovf_q & ~i_clr_err) | (i_wr_en & full);
      unf_d = (unf_q & ~i_clr_err) | (i_rd_en & empty);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; writes are blocked while reset is held.
   always_ff @(posedge i_clk) begin
      if (wa && !i_rst) mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign o_rd_data  = mem[rd_ptr_q[AW-1:0]];
         assign o_rd_valid = ~empty;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_q, rd_data_d;
         logic             rd_valid_q, rd_valid_d;

         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = ra;
            if (ra) rd_data_d = mem[rd_ptr_q[AW-1:0]];
         end

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign o_rd_data  = rd_data_q;
         assign o_rd_valid = rd_valid_q;
      end
   endgenerate

   assign o_count        = count;
   assign o_full         = full;
   assign o_empty        = empty;
   assign o_almost_full  = (count >= i_almost_full_lim);
   assign o_almost_empty = (count <= i_almost_empty_lim);
   assign o_overflow     = ovf_q;
   assign o_underflow    = unf_q;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO that succeeds the team's dual-pointer FIFO.
- Uses all DEPTH entries, using an extra pointer wrap bit for full/empty.
- Offers a standard mode (registered read) and a first-word-fall-through (FWFT) mode.
- Provides occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between producer/consumer datapaths in the same clock domain.

Parameters:
- DEPTH, 64, number of entries; power of two, minimum 4.
- WIDTH, 8, data word width in bits.
- FWFT, 0, read mode: 0 = standard (data one cycle after accepted read), 1 = first-word fall-through.
- AW (local), $clog2(DEPTH), address width. Pointers and count are AW+1 bits.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr_en  in  1  write request.
- i_wr_data  in  WIDTH  write data.
- i_rd_en  in  1  read request (FWFT: pop/acknowledge of the head word).
- i_almost_full_lim  in  AW+1  almost-full threshold (0..DEPTH).
- i_almost_empty_lim  in  AW+1  almost-empty threshold (0..DEPTH).
- i_clr_err  in  1  clears the sticky error flags.
- o_rd_data  out  WIDTH  read data.
- o_rd_valid  out  1  o_rd_data is valid.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= i_almost_full_lim.
- o_almost_empty  out  1  count <= i_almost_empty_lim.
- o_count  out  AW+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, o_count = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = (i_almost_full_lim == 0), o_rd_valid = 0 in standard mode, o_rd_data = 0 in standard mode, o_overflow = o_underflow = 0. The memory array is not reset.
- Reset mid-operation discards all contents immediately. An i_wr_en/i_rd_en asserted during reset is ignored.
- Write accepted (wa) = i_wr_en & ~o_full. On wa: mem[wr_ptr[AW-1:0]] <= i_wr_data, and wr_ptr increments.
- Read accepted (ra) = i_rd_en & ~o_empty. On ra: rd_ptr increments.
- Simultaneous wa and ra are both accepted. Count is unchanged and no flag toggles.
- Write while full: data is dropped and pointer unchanged. This holds even if a read is accepted in the same cycle: no pass-through at full.
- Read while empty: no pointer change. This holds even if a write is accepted in the same cycle: no pass-through at empty.
- Wrap-around: pointers roll over modulo 2*DEPTH. count = wr_ptr - rd_ptr (AW+1 bit subtraction).
- Full/empty: full when MSBs differ and lower AW bits are equal; empty when pointers are equal.
- Status decode: o_count and all flags are combinational decodes of the registered pointers. They reflect an accepted operation in the cycle after its edge.
- Standard mode (FWFT=0):
  - On ra, o_rd_data <= head word, and o_rd_valid = 1 for exactly the next cycle.
  - Without ra, o_rd_valid = 0 and o_rd_data holds its last value.
  - Latency: 1 cycle from accepted read to data.
- FWFT mode (FWFT=1):
  - o_rd_valid = ~o_empty.
  - o_rd_data = mem[rd_ptr] (asynchronous array read); it is undefined while o_rd_valid = 0.
  - A word written at edge N is visible with o_rd_valid = 1 in cycle N+1.
  - i_rd_en with o_rd_valid = 1 pops the head word, and the next word appears in the following cycle.
- Error flags:
  - o_overflow sets on i_wr_en & o_full.
  - o_underflow sets on i_rd_en & o_empty.
  - Both flags remain set until i_clr_err. If set and clear occur in the same cycle, set wins.
- Thresholds are sampled combinationally and may change at any time.
  - i_almost_full_lim = 0 forces o_almost_full = 1.
  - i_almost_empty_lim >= DEPTH forces o_almost_empty = 1.

Test Plan:
1. DEPTH=64, FWFT=0: write 0x00..0x3F back-to-back -> o_full rises the cycle after the 64th write and o_count = 64. A 65th write -> o_overflow = 1, o_count stays 64. Reading all 64 returns 0x00..0x3F in order, o_rd_valid one cycle after each accepted read, and o_empty = 1 after the last.
2. At full, assert wr+rd together with data 0xAA -> write is dropped, count becomes 63, o_overflow = 1. At count 10, assert simultaneous wr+rd -> count stays 10, and o_full/o_empty do not toggle.
3. Empty FIFO: assert i_rd_en -> o_underflow = 1, o_rd_valid stays 0, o_rd_data holds its prior value. Pulse i_clr_err -> flag cleared. Clear in the same cycle as a new underflow -> flag stays 1.
4. Wrap-around: 300 cycles of random wr/rd with an incrementing data pattern -> read order is exact, o_count always equals the model, and pointers wrap past 2*DEPTH without corruption.
5. FWFT=1: write 0x55 at edge N -> o_rd_valid = 1 and o_rd_data = 0x55 in cycle N+1 with no read. Pop with i_rd_en -> o_rd_valid = 0 the next cycle, when the FIFO held only that word.
6. Thresholds: almost_full_lim = 60, almost_empty_lim = 4. Fill to 59 -> o_almost_full = 0; fill to 60 -> o_almost_full = 1; drain to 5 -> o_almost_empty = 0; drain to 4 -> o_almost_empty = 1. Assert i_rst at count 30 -> o_count = 0 and o_empty = 1 immediately, before any clock edge.
